memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 174 +++++++++++++++++
 tb/tb_memory_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// Memory stage of the pipeline. Non-memory instructions pass through to
// Writeback with one cycle of latency. Loads and stores are issued as a single
// registered bus request. The stage then stalls Execute until the memory
// acknowledges the access or the wait budget runs out.
//
// Parameters
//   TIMEOUT_CYCLES      WAIT cycles without mem_ack before the access is
//                       aborted (1..255).
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   ex_mem_*            instruction fields arriving from Execute
//   mem_req/we/addr/wdata
//                       registered bus request, held for the whole access
//   mem_rdata, mem_ack  load data and one-cycle completion strobe
//   mem_stall           registered hold for Execute and earlier stages
//   mem_err             one-cycle pulse on a misaligned or timed-out access
//   mem_wb_*            destination, write enable and value for Writeback
//   mem_access_count    number of acknowledged accesses (wraps at 16 bits)
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  // Execute side
  input  logic        ex_mem_readmem,
  input  logic        ex_mem_writemem,
  input  logic [31:0] ex_mem_regb,
  input  logic        ex_mem_selwsource,
  input  logic [4:0]  ex_mem_regdest,
  input  logic        ex_mem_writereg,
  input  logic [31:0] ex_mem_wbvalue,
  // Memory bus
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  // Pipeline control and status
  output logic        mem_stall,
  output logic        mem_err,
  // Writeback side
  output logic [4:0]  mem_wb_regdest,
  output logic        mem_wb_writereg,
  output logic [31:0] mem_wb_wbvalue,
  output logic [15:0] mem_access_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  // The abort fires on the edge that would otherwise move the counter to
  // TIMEOUT_CYCLES. This gives exactly TIMEOUT_CYCLES WAIT cycles with
  // mem_req high.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state;
  logic [7:0]  wait_cnt;

  // Instruction fields captured when an access is issued. Execute is stalled
  // while the access is in flight, so the live ex_mem_* values cannot be used.
  logic [4:0]  regdest_p1;
  logic        writereg_p1;
  logic        selwsource_p1;
  logic [31:0] wbvalue_p1;

  logic        access_req;
  logic        access_aligned;
  logic        timeout_hit;

  function automatic logic is_word_aligned(input logic [31:0] byte_addr);
    return (byte_addr[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] wb_select(input logic        from_mem,
                                            input logic [31:0] rdata,
                                            input logic [31:0] alu_value);
    return from_mem ? rdata : alu_value;
  endfunction

  always_comb begin
    access_req     = ex_mem_readmem | ex_mem_writemem;
    access_aligned = is_word_aligned(ex_mem_wbvalue);
    timeout_hit    = (wait_cnt == TIMEOUT_LAST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wait_cnt         <= 8'd0;
      regdest_p1       <= 5'd0;
      writereg_p1      <= 1'b0;
      selwsource_p1    <= 1'b0;
      wbvalue_p1       <= 32'd0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= 32'd0;
      mem_wdata        <= 32'd0;
      mem_stall        <= 1'b0;
      mem_err          <= 1'b0;
      mem_wb_regdest   <= 5'd0;
      mem_wb_writereg  <= 1'b0;
      mem_wb_wbvalue   <= 32'd0;
      mem_access_count <= 16'd0;
    end else begin
      // mem_err is a strobe; it is raised only on the edge that detects
      // the fault.
      mem_err <= 1'b0;

      case (state)
        // ---- Issue stage: pass-through or request launch ----
        IDLE: begin
          if (!access_req) begin
            mem_wb_regdest  <= ex_mem_regdest;
            mem_wb_writereg <= ex_mem_writereg;
            mem_wb_wbvalue  <= ex_mem_wbvalue;
          end else if (!access_aligned) begin
            // A misaligned access is dropped here. Writeback gets a bubble
            // and the bus is never touched.
            mem_err         <= 1'b1;
            mem_wb_writereg <= 1'b0;
          end else begin
            mem_req         <= 1'b1;
            // A store wins when Execute asserts both read and write.
            mem_we          <= ex_mem_writemem;
            mem_addr        <= ex_mem_wbvalue;
            mem_wdata       <= ex_mem_regb;
            regdest_p1      <= ex_mem_regdest;
            writereg_p1     <= ex_mem_writereg;
            selwsource_p1   <= ex_mem_selwsource;
            wbvalue_p1      <= ex_mem_wbvalue;
            mem_stall       <= 1'b1;
            mem_wb_writereg <= 1'b0;
            wait_cnt        <= 8'd0;
            state           <= WAIT;
          end
        end

        // ---- Wait stage: bus outputs hold until ack or timeout ----
        WAIT: begin
          if (mem_ack) begin
            // An ack wins over a timeout on the same edge.
            mem_req          <= 1'b0;
            mem_stall        <= 1'b0;
            mem_access_count <= mem_access_count + 16'd1;
            mem_wb_regdest   <= regdest_p1;
            // A store never writes a register, whatever Execute asked for.
            mem_wb_writereg  <= writereg_p1 & ~mem_we;
            mem_wb_wbvalue   <= wb_select(selwsource_p1, mem_rdata, wbvalue_p1);
            state            <= IDLE;
          end else if (timeout_hit) begin
            mem_req         <= 1'b0;
            mem_stall       <= 1'b0;
            mem_err         <= 1'b1;
            mem_wb_writereg <= 1'b0;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//
// Directed bench for memory_stage (TIMEOUT_CYCLES = 4). The stimulus pushes
// the expected bus request and the expected Writeback or error result into
// queues. A monitor on the falling edge pops and compares whenever the DUT
// raises a request, completes an access or pulses mem_err.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] val;
  } resp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_mem_readmem = 1'b0;
  logic        ex_mem_writemem = 1'b0;
  logic [31:0] ex_mem_regb = 32'd0;
  logic        ex_mem_selwsource = 1'b0;
  logic [4:0]  ex_mem_regdest = 5'd0;
  logic        ex_mem_writereg = 1'b0;
  logic [31:0] ex_mem_wbvalue = 32'd0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        mem_stall;
  logic        mem_err;
  logic [4:0]  mem_wb_regdest;
  logic        mem_wb_writereg;
  logic [31:0] mem_wb_wbvalue;
  logic [15:0] mem_access_count;

  int total = 0;
  int bad   = 0;

  req_t  req_q[$];
  resp_t resp_q[$];

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .ex_mem_readmem   (ex_mem_readmem),
    .ex_mem_writemem  (ex_mem_writemem),
    .ex_mem_regb      (ex_mem_regb),
    .ex_mem_selwsource(ex_mem_selwsource),
    .ex_mem_regdest   (ex_mem_regdest),
    .ex_mem_writereg  (ex_mem_writereg),
    .ex_mem_wbvalue   (ex_mem_wbvalue),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_ack          (mem_ack),
    .mem_stall        (mem_stall),
    .mem_err          (mem_err),
    .mem_wb_regdest   (mem_wb_regdest),
    .mem_wb_writereg  (mem_wb_writereg),
    .mem_wb_wbvalue   (mem_wb_wbvalue),
    .mem_access_count (mem_access_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ex_mem_readmem    = 1'b0;
    ex_mem_writemem   = 1'b0;
    ex_mem_regb       = 32'd0;
    ex_mem_selwsource = 1'b0;
    ex_mem_regdest    = 5'd0;
    ex_mem_writereg   = 1'b0;
    ex_mem_wbvalue    = 32'd0;
  endtask

  // Monitor: compares bus requests and access results against the queues.
  initial begin : monitor
    logic prev_req;
    logic prev_stall;
    req_t  er;
    resp_t ep;
    prev_req   = 1'b0;
    prev_stall = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_req   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          if (req_q.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
          end else begin
            er = req_q.pop_front();
            check("req_we", {31'd0, mem_we}, {31'd0, er.we});
            check("req_addr", mem_addr, er.addr);
            check("req_wdata", mem_wdata, er.wdata);
          end
        end
        if (mem_err || (prev_stall && !mem_stall)) begin
          if (resp_q.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            ep = resp_q.pop_front();
            check("resp_err", {31'd0, mem_err}, {31'd0, ep.err});
            check("resp_writereg", {31'd0, mem_wb_writereg}, {31'd0, ep.wr});
            if (!ep.err) begin
              check("resp_regdest", {27'd0, mem_wb_regdest}, {27'd0, ep.rd});
              check("resp_wbvalue", mem_wb_wbvalue, ep.val);
            end
          end
        end
        prev_req   = mem_req;
        prev_stall = mem_stall;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    // Reset state
    idle_inputs();
    ex_mem_wbvalue = 32'h1234_5678;
    ex_mem_writereg = 1'b1;
    tick();
    tick();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_wb_value", mem_wb_wbvalue, 32'd0);
    check("rst_wb_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    check("rst_count", {16'd0, mem_access_count}, 32'd0);
    reset = 1'b1;

    // ALU pass-through
    ex_mem_wbvalue  = 32'd7;
    ex_mem_regdest  = 5'd3;
    ex_mem_writereg = 1'b1;
    tick();
    check("pt_wbvalue", mem_wb_wbvalue, 32'd7);
    check("pt_regdest", {27'd0, mem_wb_regdest}, 32'd3);
    check("pt_writereg", {31'd0, mem_wb_writereg}, 32'd1);
    check("pt_req", {31'd0, mem_req}, 32'd0);

    // Load with ack after 3 WAIT cycles
    ex_mem_readmem    = 1'b1;
    ex_mem_wbvalue    = 32'h100;
    ex_mem_selwsource = 1'b1;
    ex_mem_regdest    = 5'd5;
    ex_mem_writereg   = 1'b1;
    ex_mem_regb       = 32'hAAAA_5555;
    req_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'hAAAA_5555});
    resp_q.push_back('{err: 1'b0, rd: 5'd5, wr: 1'b1, val: 32'hDEAD_BEEF});
    tick();
    check("ld_req_c1", {31'd0, mem_req}, 32'd1);
    check("ld_stall_c1", {31'd0, mem_stall}, 32'd1);
    check("ld_bubble", {31'd0, mem_wb_writereg}, 32'd0);
    // Execute inputs change during WAIT; they must be ignored.
    ex_mem_readmem = 1'b0;
    ex_mem_writemem = 1'b1;
    ex_mem_wbvalue = 32'h55;
    ex_mem_regdest = 5'd31;
    tick();
    check("ld_req_c2", {31'd0, mem_req}, 32'd1);
    check("ld_addr_hold", mem_addr, 32'h100);
    tick();
    check("ld_req_c3", {31'd0, mem_req}, 32'd1);
    check("ld_stall_c3", {31'd0, mem_stall}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    idle_inputs();
    ex_mem_wbvalue  = 32'd7;
    ex_mem_regdest  = 5'd3;
    tick();
    mem_ack = 1'b0;
    check("ld_req_done", {31'd0, mem_req}, 32'd0);
    check("ld_stall_done", {31'd0, mem_stall}, 32'd0);
    check("ld_count", {16'd0, mem_access_count}, 32'd1);

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_count", {16'd0, mem_access_count}, 32'd1);
    check("idle_ack_req", {31'd0, mem_req}, 32'd0);
    check("idle_ack_stall", {31'd0, mem_stall}, 32'd0);

    // Store (both read and write asserted: store wins), immediate ack
    ex_mem_readmem  = 1'b1;
    ex_mem_writemem = 1'b1;
    ex_mem_wbvalue  = 32'h200;
    ex_mem_regb     = 32'h1234_5678;
    ex_mem_regdest  = 5'd9;
    ex_mem_writereg = 1'b1;
    req_q.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'h1234_5678});
    resp_q.push_back('{err: 1'b0, rd: 5'd9, wr: 1'b0, val: 32'h200});
    tick();
    check("st_we", {31'd0, mem_we}, 32'd1);
    check("st_addr", mem_addr, 32'h200);
    check("st_wdata", mem_wdata, 32'h1234_5678);
    // Queue the next load on Execute while the ack arrives.
    mem_ack           = 1'b1;
    ex_mem_writemem   = 1'b0;
    ex_mem_readmem    = 1'b1;
    ex_mem_wbvalue    = 32'h300;
    ex_mem_selwsource = 1'b0;
    ex_mem_regdest    = 5'd7;
    ex_mem_writereg   = 1'b1;
    ex_mem_regb       = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    check("st_done_req", {31'd0, mem_req}, 32'd0);
    check("st_wb_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    check("st_count", {16'd0, mem_access_count}, 32'd2);

    // Back-to-back: the first IDLE edge accepts the queued load
    req_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0BAD_F00D});
    resp_q.push_back('{err: 1'b0, rd: 5'd7, wr: 1'b1, val: 32'h300});
    tick();
    check("b2b_req", {31'd0, mem_req}, 32'd1);
    idle_inputs();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    tick();
    mem_ack = 1'b0;
    check("b2b_count", {16'd0, mem_access_count}, 32'd3);
    check("b2b_alu_value", mem_wb_wbvalue, 32'h300);

    // Misaligned load
    ex_mem_readmem  = 1'b1;
    ex_mem_wbvalue  = 32'h102;
    ex_mem_regdest  = 5'd4;
    ex_mem_writereg = 1'b1;
    resp_q.push_back('{err: 1'b1, rd: 5'd0, wr: 1'b0, val: 32'd0});
    tick();
    check("mis_err", {31'd0, mem_err}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_writereg", {31'd0, mem_wb_writereg}, 32'd0);
    idle_inputs();
    tick();
    check("mis_err_pulse", {31'd0, mem_err}, 32'd0);
    check("mis_req_after", {31'd0, mem_req}, 32'd0);

    // Timeout: never ack
    ex_mem_readmem  = 1'b1;
    ex_mem_wbvalue  = 32'h400;
    ex_mem_regdest  = 5'd2;
    ex_mem_writereg = 1'b1;
    req_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'd0});
    resp_q.push_back('{err: 1'b1, rd: 5'd0, wr: 1'b0, val: 32'd0});
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_req_hold", {31'd0, mem_req}, 32'd1);
      check("to_no_err", {31'd0, mem_err}, 32'd0);
    end
    tick();
    check("to_err", {31'd0, mem_err}, 32'd1);
    check("to_req", {31'd0, mem_req}, 32'd0);
    check("to_stall", {31'd0, mem_stall}, 32'd0);
    check("to_count", {16'd0, mem_access_count}, 32'd3);
    tick();
    check("to_err_pulse", {31'd0, mem_err}, 32'd0);

    // Ack on the timeout edge completes normally
    ex_mem_readmem    = 1'b1;
    ex_mem_wbvalue    = 32'h600;
    ex_mem_selwsource = 1'b1;
    ex_mem_regdest    = 5'd6;
    ex_mem_writereg   = 1'b1;
    req_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'd0});
    resp_q.push_back('{err: 1'b0, rd: 5'd6, wr: 1'b1, val: 32'hCAFE_F00D});
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    check("race_err", {31'd0, mem_err}, 32'd0);
    check("race_count", {16'd0, mem_access_count}, 32'd4);

    // Reset asserted mid-WAIT
    ex_mem_readmem = 1'b1;
    ex_mem_wbvalue = 32'h500;
    req_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'd0});
    tick();
    idle_inputs();
    tick();
    check("mid_req_before", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_req", {31'd0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wbvalue", mem_wb_wbvalue, 32'd0);
    check("mid_rst_count", {16'd0, mem_access_count}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_req", {31'd0, mem_req}, 32'd0);
    check("req_q_empty", req_q.size(), 32'd0);
    check("resp_q_empty", resp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
